// File: rtl/aes_ahb_slave.sv
// AHB-Lite register slave for an AES controller: collects a 128-bit key and plaintext block,
// exposes the ciphertext for readback, and hands a complete set to the datapath via dataReady.
module aes_ahb_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         HSELx,
    input  logic [31:0]  HADDR,
    input  logic [1:0]   HTRANS,
    input  logic         HWRITE,
    input  logic [2:0]   HSIZE,
    input  logic [31:0]  HWDATA,
    input  logic         HREADY,
    input  logic [127:0] cipher_in,
    input  logic         result_valid,
    input  logic         data_taken,
    output logic         addrMatch,
    output logic         mWrite,
    output logic         mRead,
    output logic         dataReady,
    output logic         invalid,
    output logic [127:0] key_out,
    output logic [127:0] data_out,
    output logic [31:0]  HRDATA
);

    typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_READY} state_t;

    state_t         state_q, state_d;
    logic           dp_valid_q, dp_valid_d;
    logic [7:0]     offset_q, offset_d;
    logic           write_q, write_d;
    logic [2:0]     size_q, size_d;
    logic           hit_q, hit_d;
    logic           addr_match_q, addr_match_d;
    logic           data_ready_q, data_ready_d;
    logic [3:0]     key_mask_q, key_mask_d;
    logic [3:0]     data_mask_q, data_mask_d;
    logic [127:0]   key_q, key_d;
    logic [127:0]   data_q, data_d;

    logic           accept;
    logic [1:0]     region;
    logic [1:0]     lane;
    logic [6:0]     lsb;
    logic           bad;
    logic           wr_ok;
    logic           rd_ok;

    always_comb begin
        accept       = HSELx & HREADY & HTRANS[1];
        dp_valid_d   = accept;
        offset_d     = accept ? HADDR[7:0] : 8'h00;
        write_d      = accept & HWRITE;
        size_d       = accept ? HSIZE : 3'b000;
        hit_d        = accept & (HADDR[31:8] == BASE_ADDR[31:8]);
        addr_match_d = hit_d;

        region = offset_q[5:4];
        // word 0 sits in the top lane, so the lane index is the inverted word number
        lane   = ~offset_q[3:2];
        lsb    = {lane, 5'b00000};

        bad = (size_q != 3'b010)
            || (offset_q[1:0] != 2'b00)
            || (offset_q >= 8'h30)
            || !hit_q
            || (write_q && region == 2'd2)
            || (write_q && region != 2'd2 && state_q == ST_READY)
            || (!write_q && region == 2'd2 && !result_valid);

        wr_ok = dp_valid_q & ~bad & write_q;
        rd_ok = dp_valid_q & ~bad & ~write_q;

        key_d       = key_q;
        data_d      = data_q;
        key_mask_d  = key_mask_q;
        data_mask_d = data_mask_q;
        if (wr_ok && region == 2'd0) begin
            key_d[lsb +: 32]           = HWDATA;
            key_mask_d[offset_q[3:2]]  = 1'b1;
        end
        if (wr_ok && region == 2'd1) begin
            data_d[lsb +: 32]          = HWDATA;
            data_mask_d[offset_q[3:2]] = 1'b1;
        end

        state_d = state_q;
        if (state_q == ST_READY) begin
            // key is kept so the next block only needs new plaintext
            if (data_taken) begin
                state_d     = ST_COLLECT;
                data_mask_d = 4'h0;
            end
        end else if ((&key_mask_d) && (&data_mask_d)) begin
            state_d = ST_READY;
        end else if ((|key_mask_d) || (|data_mask_d)) begin
            state_d = ST_COLLECT;
        end else begin
            state_d = ST_IDLE;
        end
        data_ready_d = (state_d == ST_READY);

        HRDATA = 32'h0;
        if (rd_ok && region == 2'd1) HRDATA = data_q[lsb +: 32];
        if (rd_ok && region == 2'd2) HRDATA = cipher_in[lsb +: 32];
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= ST_IDLE;
            dp_valid_q   <= 1'b0;
            offset_q     <= 8'h00;
            write_q      <= 1'b0;
            size_q       <= 3'b000;
            hit_q        <= 1'b0;
            addr_match_q <= 1'b0;
            data_ready_q <= 1'b0;
            key_mask_q   <= 4'h0;
            data_mask_q  <= 4'h0;
            key_q        <= '0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            dp_valid_q   <= dp_valid_d;
            offset_q     <= offset_d;
            write_q      <= write_d;
            size_q       <= size_d;
            hit_q        <= hit_d;
            addr_match_q <= addr_match_d;
            data_ready_q <= data_ready_d;
            key_mask_q   <= key_mask_d;
            data_mask_q  <= data_mask_d;
            key_q        <= key_d;
            data_q       <= data_d;
        end
    end

    assign addrMatch = addr_match_q;
    assign mWrite    = wr_ok;
    assign mRead     = rd_ok;
    assign invalid   = dp_valid_q & bad;
    assign dataReady = data_ready_q;
    assign key_out   = key_q;
    assign data_out  = data_q;

endmodule

// File: tb/tb_aes_ahb_slave.sv
// Directed bench for aes_ahb_slave: a vector table of single transfers plus hand-written
// sequences for data_taken handling, IDLE/BUSY filtering and asynchronous reset.
module tb_aes_ahb_slave;

    logic         clk;
    logic         n_rst;
    logic         HSELx;
    logic [31:0]  HADDR;
    logic [1:0]   HTRANS;
    logic         HWRITE;
    logic [2:0]   HSIZE;
    logic [31:0]  HWDATA;
    logic         HREADY;
    logic [127:0] cipher_in;
    logic         result_valid;
    logic         data_taken;
    logic         addrMatch;
    logic         mWrite;
    logic         mRead;
    logic         dataReady;
    logic         invalid;
    logic [127:0] key_out;
    logic [127:0] data_out;
    logic [31:0]  HRDATA;

    aes_ahb_slave dut (
        .clk(clk), .n_rst(n_rst), .HSELx(HSELx), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
        .cipher_in(cipher_in), .result_valid(result_valid), .data_taken(data_taken),
        .addrMatch(addrMatch), .mWrite(mWrite), .mRead(mRead), .dataReady(dataReady),
        .invalid(invalid), .key_out(key_out), .data_out(data_out), .HRDATA(HRDATA)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic        e_am;
        logic        e_mw;
        logic        e_mr;
        logic        e_inv;
        logic [31:0] e_rd;
        logic        e_rdy;
    } vec_t;

    localparam int NV = 17;
    localparam logic [127:0] KEY1 = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
    localparam logic [127:0] PT1  = 128'h6BC1BEE22E409F96E93D7E117393172A;
    localparam logic [127:0] PT2  = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] KEY2 = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] CT   = 128'h3925841D02DC09FBDC118597196A0B32;

    vec_t vecs [NV];
    int checks = 0;
    int errors = 0;
    logic        am_s, mw_s, mr_s, inv_s;
    logic [31:0] rd_s;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // one non-pipelined transfer; outputs sampled on the falling edge of the data phase
    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                        input logic [31:0] wdata, input logic dt);
        HSELx = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = wr; HSIZE = size;
        @(posedge clk); #1;
        HSELx = 1'b0; HTRANS = 2'b00; HWDATA = wdata; data_taken = dt;
        @(negedge clk);
        am_s = addrMatch; mw_s = mWrite; mr_s = mRead; inv_s = invalid; rd_s = HRDATA;
        @(posedge clk); #1;
        data_taken = 1'b0;
    endtask

    task automatic wr4(input logic [31:0] base, input logic [127:0] val, input int n);
        for (int k = 0; k < n; k++)
            xfer(base + 32'(4 * k), 1'b1, 3'd2, val[127 - 32 * k -: 32], 1'b0);
    endtask

    task automatic pulse_dt();
        data_taken = 1'b1;
        @(posedge clk); #1;
        data_taken = 1'b0;
    endtask

    initial begin
        n_rst = 1'b0; HSELx = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
        HSIZE = 3'd2; HWDATA = '0; HREADY = 1'b1; cipher_in = CT; result_valid = 1'b1;
        data_taken = 1'b0;

        vecs[0]  = '{32'h8000_0000, 1'b1, 3'd2, 32'h2B7E1516, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0};
        vecs[1]  = '{32'h8000_0004, 1'b1, 3'd2, 32'h28AED2A6, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0};
        vecs[2]  = '{32'h8000_0008, 1'b1, 3'd2, 32'hABF71588, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0};
        vecs[3]  = '{32'h8000_000C, 1'b1, 3'd2, 32'h09CF4F3C, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0};
        vecs[4]  = '{32'h8000_0010, 1'b1, 3'd2, 32'h6BC1BEE2, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0};
        vecs[5]  = '{32'h8000_0014, 1'b1, 3'd2, 32'h2E409F96, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0};
        vecs[6]  = '{32'h8000_0018, 1'b1, 3'd2, 32'hE93D7E11, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0};
        vecs[7]  = '{32'h8000_0014, 1'b0, 3'd2, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'h2E409F96, 1'b0};
        vecs[8]  = '{32'h8000_0004, 1'b0, 3'd2, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0};
        vecs[9]  = '{32'h8000_0010, 1'b1, 3'd0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0};
        vecs[10] = '{32'h8000_0024, 1'b1, 3'd2, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0};
        vecs[11] = '{32'h8000_0012, 1'b1, 3'd2, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0};
        vecs[12] = '{32'h9000_0010, 1'b1, 3'd2, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0};
        vecs[13] = '{32'h8000_0028, 1'b0, 3'd2, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'hDC118597, 1'b0};
        vecs[14] = '{32'h8000_001C, 1'b1, 3'd2, 32'h7393172A, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1};
        vecs[15] = '{32'h8000_0000, 1'b1, 3'd2, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1};
        vecs[16] = '{32'h8000_0030, 1'b0, 3'd2, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1};

        #2;
        chk("reset_flags", {123'h0, addrMatch, mWrite, mRead, dataReady, invalid}, 128'h0);
        chk("reset_key", key_out, 128'h0);
        chk("reset_hrdata", {96'h0, HRDATA}, 128'h0);
        @(posedge clk); #2 n_rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            xfer(vecs[i].addr, vecs[i].wr, vecs[i].size, vecs[i].wdata, 1'b0);
            chk($sformatf("v%0d_addrmatch", i), {127'h0, am_s}, {127'h0, vecs[i].e_am});
            chk($sformatf("v%0d_mwrite", i), {127'h0, mw_s}, {127'h0, vecs[i].e_mw});
            chk($sformatf("v%0d_mread", i), {127'h0, mr_s}, {127'h0, vecs[i].e_mr});
            chk($sformatf("v%0d_invalid", i), {127'h0, inv_s}, {127'h0, vecs[i].e_inv});
            chk($sformatf("v%0d_hrdata", i), {96'h0, rd_s}, {96'h0, vecs[i].e_rd});
            chk($sformatf("v%0d_ready", i), {127'h0, dataReady}, {127'h0, vecs[i].e_rdy});
        end
        chk("tbl_key_out", key_out, KEY1);
        chk("tbl_data_out", data_out, PT1);

        result_valid = 1'b0;
        xfer(32'h8000_0028, 1'b0, 3'd2, 32'h0, 1'b0);
        chk("ct_norv_invalid", {126'h0, inv_s, mr_s}, 128'h2);
        chk("ct_norv_hrdata", {96'h0, rd_s}, 128'h0);
        result_valid = 1'b1;

        // plaintext write colliding with data_taken in READY
        xfer(32'h8000_0010, 1'b1, 3'd2, 32'hDEADBEEF, 1'b1);
        chk("coll_invalid", {126'h0, inv_s, mw_s}, 128'h2);
        chk("coll_ready", {127'h0, dataReady}, 128'h0);
        chk("coll_data_out", data_out, PT1);
        chk("coll_key_out", key_out, KEY1);

        wr4(32'h8000_0010, PT2, 3);
        chk("col3_ready", {127'h0, dataReady}, 128'h0);
        pulse_dt();
        chk("dt_collect_ready", {127'h0, dataReady}, 128'h0);
        xfer(32'h8000_001C, 1'b1, 3'd2, PT2[31:0], 1'b0);
        chk("col4_ready", {127'h0, dataReady}, 128'h1);
        chk("col4_data_out", data_out, PT2);

        pulse_dt();
        chk("taken_ready", {127'h0, dataReady}, 128'h0);
        chk("taken_key", key_out, KEY1);
        wr4(32'h8000_0010, PT1, 3);
        chk("reuse3_ready", {127'h0, dataReady}, 128'h0);
        xfer(32'h8000_001C, 1'b1, 3'd2, PT1[31:0], 1'b0);
        chk("reuse4_ready", {127'h0, dataReady}, 128'h1);
        chk("reuse4_data", data_out, PT1);

        // IDLE then BUSY address phases to a write-legal offset
        HSELx = 1'b1; HTRANS = 2'b00; HADDR = 32'h8000_0010; HWRITE = 1'b1; HSIZE = 3'd2;
        @(posedge clk); #1;
        HTRANS = 2'b01; HWDATA = 32'hFFFFFFFF;
        @(negedge clk);
        chk("idle_flags", {124'h0, addrMatch, mWrite, mRead, invalid}, 128'h0);
        @(posedge clk); #1;
        HSELx = 1'b0; HTRANS = 2'b00;
        @(negedge clk);
        chk("busy_flags", {124'h0, addrMatch, mWrite, mRead, invalid}, 128'h0);
        @(posedge clk); #1;
        chk("idlebusy_ready", {127'h0, dataReady}, 128'h1);
        chk("idlebusy_data", data_out, PT1);

        pulse_dt();
        wr4(32'h8000_0010, PT2, 3);
        HSELx = 1'b1; HTRANS = 2'b10; HADDR = 32'h8000_0028; HWRITE = 1'b0;
        @(posedge clk); #1;
        HSELx = 1'b0; HTRANS = 2'b00;
        @(negedge clk);
        chk("prerst_read", {95'h0, mRead, HRDATA}, {95'h0, 1'b1, 32'hDC118597});
        #2 n_rst = 1'b0;
        #1;
        chk("rst_flags", {123'h0, addrMatch, mWrite, mRead, dataReady, invalid}, 128'h0);
        chk("rst_hrdata", {96'h0, HRDATA}, 128'h0);
        chk("rst_key", key_out, 128'h0);
        chk("rst_data", data_out, 128'h0);
        @(posedge clk); #2 n_rst = 1'b1;
        @(posedge clk); #1;
        wr4(32'h8000_0010, PT2, 4);
        chk("postrst_pt_ready", {127'h0, dataReady}, 128'h0);
        wr4(32'h8000_0000, KEY2, 3);
        chk("postrst_7_ready", {127'h0, dataReady}, 128'h0);
        xfer(32'h8000_000C, 1'b1, 3'd2, KEY2[31:0], 1'b0);
        chk("postrst_8_ready", {127'h0, dataReady}, 128'h1);
        chk("postrst_key", key_out, KEY2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
